// File: rtl/activation_unit.sv
// Two-stage activation pipeline: clamps a wide signed accumulator to a Q(INT_W) window
// and applies ReLU / leaky ReLU / hard sigmoid / saturating pass, with an overflow counter.
module activation_unit #(
  parameter int DATA_W  = 16,
  parameter int IN_W    = 2*DATA_W,
  parameter int INT_W   = 4,
  parameter int LEAK_SH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              sat_clr,
  output logic [15:0]       sat_count
);
  localparam int STAGES = 2;
  localparam int FRAC_W = DATA_W-1-INT_W;
  localparam logic signed [DATA_W-1:0] MAXP   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MAXN   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W:0]   ONE_W  = (DATA_W+1)'(1) << FRAC_W;
  localparam logic signed [DATA_W:0]   HALF_W = ONE_W >>> 1;

  logic advance, accept;
  logic [STAGES:1] vld_pipe_d, vld_pipe_q;

  assign advance   = !vld_pipe_q[STAGES] || out_ready;
  assign in_ready  = advance;
  assign accept    = in_valid && advance;
  assign out_valid = vld_pipe_q[STAGES];

  // stage 0: window extraction and clamp
  logic [INT_W:0]            top;
  logic                      in_neg, pos_ovf, neg_ovf;
  logic signed [DATA_W-1:0]  clamped;

  always_comb begin
    top     = in_data[IN_W-1 -: INT_W+1];
    in_neg  = in_data[IN_W-1];
    pos_ovf = !in_neg && (|top);
    neg_ovf = in_neg && !(&top);
    if (pos_ovf)      clamped = MAXP;
    else if (neg_ovf) clamped = MAXN;
    else              clamped = in_data[IN_W-1-INT_W -: DATA_W];
  end

  // stage 1 registers
  logic signed [DATA_W-1:0] s1_data_d, s1_data_q;
  logic                     s1_neg_d, s1_neg_q, s1_ovf_d, s1_ovf_q;
  logic [1:0]               s1_mode_d, s1_mode_q;
  logic [DATA_W-1:0]        out_data_d, out_data_q;
  logic [15:0]              sat_d, sat_q;

  // stage 2: mode result
  logic signed [DATA_W:0]   wide, sum;
  logic [DATA_W-1:0]        res;

  always_comb begin
    wide = {s1_data_q[DATA_W-1], s1_data_q};
    sum  = (wide >>> 2) + HALF_W;
    case (s1_mode_q)
      2'd0: res = s1_neg_q ? '0 : s1_data_q;
      2'd1: res = s1_neg_q ? (s1_data_q >>> LEAK_SH) : s1_data_q;
      2'd2: begin
        if (sum < 0)          res = '0;
        else if (sum > ONE_W) res = ONE_W[DATA_W-1:0];
        else                  res = sum[DATA_W-1:0];
      end
      // rail re-derived from the overflow flags; equals s1_data_q
      default: res = s1_ovf_q ? (s1_neg_q ? MAXN : MAXP) : s1_data_q;
    endcase
  end

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_data_d  = s1_data_q;
    s1_neg_d   = s1_neg_q;
    s1_ovf_d   = s1_ovf_q;
    s1_mode_d  = s1_mode_q;
    out_data_d = out_data_q;
    if (advance) begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], accept};
      s1_data_d  = clamped;
      s1_neg_d   = in_neg;
      s1_ovf_d   = pos_ovf || neg_ovf;
      s1_mode_d  = in_mode;
      out_data_d = res;
    end
    sat_d = sat_q;
    if (sat_clr)
      sat_d = '0;
    else if (accept && (pos_ovf || neg_ovf) && (sat_q != 16'hFFFF))
      sat_d = sat_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_data_q  <= '0;
      s1_neg_q   <= 1'b0;
      s1_ovf_q   <= 1'b0;
      s1_mode_q  <= '0;
      out_data_q <= '0;
      sat_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_data_q  <= s1_data_d;
      s1_neg_q   <= s1_neg_d;
      s1_ovf_q   <= s1_ovf_d;
      s1_mode_q  <= s1_mode_d;
      out_data_q <= out_data_d;
      sat_q      <= sat_d;
    end
  end

  assign out_data  = out_data_q;
  assign sat_count = sat_q;
endmodule

// File: tb/tb_activation_unit.sv
// Directed bench for activation_unit with hand-computed expectations (DATA_W=16, IN_W=32).
module tb_activation_unit;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, sat_clr;
  logic [31:0] in_data;
  logic [1:0]  in_mode;
  logic [15:0] out_data, sat_count;
  int n_chk = 0, n_fail = 0;

  activation_unit #(.DATA_W(16), .IN_W(32), .INT_W(4), .LEAK_SH(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .sat_clr(sat_clr),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // single sample into an empty pipe; result expected two edges after acceptance
  task automatic run1(input string tag, input logic [31:0] d, input logic [1:0] m,
                      input logic [15:0] exp);
    chk({tag, " rdy"}, in_ready, 1);
    in_valid = 1'b1; in_data = d; in_mode = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, " early"}, out_valid, 0);
    @(posedge clk); #1;
    chk({tag, " vld"}, out_valid, 1);
    chk(tag, out_data, exp);
    @(posedge clk); #1;
    chk({tag, " drain"}, out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0;
    out_ready = 1'b1; sat_clr = 1'b0;
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst sat", sat_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst in_ready", in_ready, 1);

    run1("relu pos", 32'h0000_1000, 2'd0, 16'h0001);
    run1("relu neg", 32'hFFFF_F000, 2'd0, 16'h0000);
    run1("relu ovf", 32'h0800_0000, 2'd0, 16'h7FFF);
    chk("sat 1", sat_count, 1);
    run1("pass novf", 32'h8000_0000, 2'd3, 16'h8000);
    chk("sat 2", sat_count, 2);
    run1("pass mid", 32'hFFFF_E000, 2'd3, 16'hFFFE);
    run1("leaky neg", 32'hFF80_0000, 2'd1, 16'hFF00);
    run1("leaky pos", 32'h0001_0000, 2'd1, 16'h0010);
    run1("hsig zero", 32'h0000_0000, 2'd2, 16'h0400);
    run1("hsig mid", 32'h0080_0000, 2'd2, 16'h0600);
    run1("hsig hi", 32'h7000_0000, 2'd2, 16'h0800);
    run1("hsig lo", 32'h9000_0000, 2'd2, 16'h0000);
    chk("sat 4", sat_count, 4);

    // back-to-back stream, mode 3: sample i has window i+1
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 4); in_data = 32'(i+1) << 12; in_mode = 2'd3;
      @(posedge clk); #1;
      if (i >= 1 && i <= 4) begin
        chk("stream vld", out_valid, 1);
        chk("stream data", out_data, 16'(i));
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("stream idle", out_valid, 0);

    // back-pressure: A,B accepted then stall; C waits
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h0000_1000; in_mode = 2'd3;
    @(posedge clk); #1;
    chk("bp rdy after A", in_ready, 1);
    in_data = 32'h0000_2000;
    @(posedge clk); #1;
    chk("bp rdy after B", in_ready, 0);
    chk("bp vld", out_valid, 1);
    chk("bp data A", out_data, 16'h0001);
    in_data = 32'h0000_3000;
    repeat (3) @(posedge clk);
    #1;
    chk("bp hold data", out_data, 16'h0001);
    chk("bp hold rdy", in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp out B", out_data, 16'h0002);
    chk("bp vld B", out_valid, 1);
    @(posedge clk); #1;
    chk("bp out C", out_data, 16'h0003);
    chk("bp vld C", out_valid, 1);
    @(posedge clk); #1;
    chk("bp empty", out_valid, 0);

    // reset with two samples in flight
    in_valid = 1'b1; in_data = 32'h0800_0000; in_mode = 2'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid rst vld", out_valid, 0);
    chk("mid rst sat", sat_count, 0);
    chk("mid rst data", out_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post rst quiet", out_valid, 0);
    end
    run1("post rst first", 32'h0000_5000, 2'd3, 16'h0005);

    // clear wins over a same-cycle increment
    run1("pre clr ovf", 32'h0800_0000, 2'd3, 16'h7FFF);
    chk("pre clr sat", sat_count, 1);
    sat_clr = 1'b1;
    in_valid = 1'b1; in_data = 32'h8000_0000; in_mode = 2'd3;
    @(posedge clk); #1;
    sat_clr = 1'b0; in_valid = 1'b0;
    chk("clr wins", sat_count, 0);
    @(posedge clk); #1;
    chk("clr sample out", out_data, 16'h8000);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
